// File: rtl/rx_check_control_module.sv
// Receive-side checker for the UART loopback demo: tracks the repeating FIRST..LAST
// byte pattern and reports lock, a saturating error count and an idle timeout.
module rx_check_control_module #(
  parameter logic [31:0] T_TIMEOUT = 32'd50_000_000,
  parameter logic [7:0]  FIRST     = 8'h0A,
  parameter logic [7:0]  LAST      = 8'h0F,
  parameter int          LOCK_N    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_Done_Sig,
  input  logic [7:0] RX_Data,
  output logic       RX_En_Sig,
  output logic [3:0] LED,
  output logic [7:0] Byte_Data,
  output logic       Locked,
  output logic [7:0] Err_Count,
  output logic       Timeout_Sig
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);
  localparam logic [0:0] S_HUNT  = 1'b0;
  localparam logic [0:0] S_TRACK = 1'b1;

  logic [0:0]    r_state;
  logic [7:0]    r_expected;
  logic [GW-1:0] r_good;
  logic [31:0]   r_idle;
  logic          r_rx_en;
  logic [7:0]    r_byte;
  logic          r_locked;
  logic [7:0]    r_err;
  logic          r_timeout;

  logic w_is_first;
  logic w_match;
  logic w_terminal;

  function automatic logic [7:0] f_err_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
  endfunction

  function automatic logic [GW-1:0] f_good_inc(input logic [GW-1:0] cnt);
    return (cnt >= GOOD_MAX) ? GOOD_MAX : cnt + GOOD_ONE;
  endfunction

  function automatic logic [7:0] f_next_exp(input logic [7:0] cur);
    return (cur == LAST) ? FIRST : cur + 8'd1;
  endfunction

  // RX_Data is only looked at while RX_Done_Sig qualifies it.
  assign w_is_first = RX_Done_Sig && (RX_Data == FIRST);
  assign w_match    = RX_Done_Sig && (RX_Data == r_expected);
  assign w_terminal = (r_idle == T_TIMEOUT - 32'd1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_HUNT;
      r_expected <= FIRST;
      r_good     <= '0;
      r_idle     <= '0;
      r_rx_en    <= 1'b0;
      r_byte     <= '0;
      r_locked   <= 1'b0;
      r_err      <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_rx_en   <= 1'b1;
      r_timeout <= 1'b0;
      if (RX_Done_Sig) r_byte <= RX_Data;
      case (r_state)
        S_HUNT: begin
          r_idle <= '0;
          if (w_is_first) begin
            r_state    <= S_TRACK;
            r_expected <= f_next_exp(FIRST);
            r_good     <= GOOD_ONE;
            r_locked   <= (GOOD_ONE == GOOD_MAX);
          end
        end
        default: begin
          // A byte arriving on the terminal cycle takes priority over the timeout.
          if (RX_Done_Sig) begin
            r_idle <= '0;
            if (w_match) begin
              r_expected <= f_next_exp(r_expected);
              r_good     <= f_good_inc(r_good);
              if (f_good_inc(r_good) == GOOD_MAX) r_locked <= 1'b1;
            end else begin
              r_err    <= f_err_inc(r_err);
              r_locked <= 1'b0;
              if (w_is_first) begin
                r_expected <= f_next_exp(FIRST);
                r_good     <= GOOD_ONE;
              end else begin
                r_state <= S_HUNT;
                r_good  <= '0;
              end
            end
          end else if (w_terminal) begin
            r_state   <= S_HUNT;
            r_locked  <= 1'b0;
            r_good    <= '0;
            r_err     <= f_err_inc(r_err);
            r_timeout <= 1'b1;
            r_idle    <= '0;
          end else begin
            r_idle <= r_idle + 32'd1;
          end
        end
      endcase
    end
  end

  assign RX_En_Sig   = r_rx_en;
  assign Byte_Data   = r_byte;
  assign LED         = r_byte[3:0];
  assign Locked      = r_locked;
  assign Err_Count   = r_err;
  assign Timeout_Sig = r_timeout;

endmodule

// File: tb/tb_rx_check_control_module.sv
// Randomized scoreboard bench for rx_check_control_module against a pattern-index model.
module tb_rx_check_control_module;

  localparam int T_TO   = 100;
  localparam int FIRST  = 8'h0A;
  localparam int LAST   = 8'h0F;
  localparam int LOCK_N = 3;
  localparam int NPAT   = LAST - FIRST + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_Done_Sig = 1'b0;
  logic [7:0] RX_Data = 8'h00;
  logic       RX_En_Sig;
  logic [3:0] LED;
  logic [7:0] Byte_Data;
  logic       Locked;
  logic [7:0] Err_Count;
  logic       Timeout_Sig;

  rx_check_control_module #(
    .T_TIMEOUT(32'd100), .FIRST(8'h0A), .LAST(8'h0F), .LOCK_N(3)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_Done_Sig(RX_Done_Sig), .RX_Data(RX_Data),
    .RX_En_Sig(RX_En_Sig), .LED(LED), .Byte_Data(Byte_Data), .Locked(Locked),
    .Err_Count(Err_Count), .Timeout_Sig(Timeout_Sig)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int en; int byte_d; int locked; int err; int to;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: position within the pattern plus counters, as plain integers.
  bit m_track = 0;
  int m_pos = 0, m_good = 0, m_idle = 0, m_err = 0;
  int m_locked = 0, m_byte = 0, m_to = 0, m_en = 0;

  function automatic int pat(input int i);
    return FIRST + i;
  endfunction

  task automatic model_step(input bit rst, input bit done, input int data);
    if (rst) begin
      m_track = 0; m_pos = 0; m_good = 0; m_idle = 0; m_err = 0;
      m_locked = 0; m_byte = 0; m_to = 0; m_en = 0;
      return;
    end
    m_en = 1; m_to = 0;
    if (done) m_byte = data;
    if (!m_track) begin
      m_idle = 0;
      if (done && data == FIRST) begin
        m_track = 1; m_pos = 1; m_good = 1;
        if (m_good >= LOCK_N) m_locked = 1;
      end
    end else if (done) begin
      m_idle = 0;
      if (data == pat(m_pos)) begin
        m_pos = (m_pos + 1) % NPAT;
        m_good = (m_good + 1 > LOCK_N) ? LOCK_N : m_good + 1;
        if (m_good == LOCK_N) m_locked = 1;
      end else begin
        m_err = (m_err < 255) ? m_err + 1 : 255;
        m_locked = 0;
        if (data == FIRST) begin
          m_pos = 1; m_good = 1;
        end else begin
          m_track = 0; m_good = 0;
        end
      end
    end else if (m_idle == T_TO - 1) begin
      m_track = 0; m_locked = 0; m_good = 0; m_idle = 0; m_to = 1;
      m_err = (m_err < 255) ? m_err + 1 : 255;
    end else begin
      m_idle++;
    end
  endtask

  task automatic drive(input bit rst, input bit done, input logic [7:0] data);
    exp_t e;
    @(negedge CLK);
    RST = rst;
    RX_Done_Sig = done;
    RX_Data = done ? data : 8'($urandom);
    model_step(rst, done, int'(data));
    e.en = m_en; e.byte_d = m_byte; e.locked = m_locked; e.err = m_err; e.to = m_to;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    drive(1'b0, 1'b1, b);
    repeat (gap) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so each cycle's expectation is compared just after its edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("RX_En_Sig", int'(RX_En_Sig), e.en);
      chk("Byte_Data", int'(Byte_Data), e.byte_d);
      chk("LED", int'(LED), e.byte_d & 15);
      chk("Locked", int'(Locked), e.locked);
      chk("Err_Count", int'(Err_Count), e.err);
      chk("Timeout_Sig", int'(Timeout_Sig), e.to);
    end
  end

  initial begin
    logic [7:0] b;
    int gap;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    // Lock with idle gaps, then ride through the wrap.
    send(8'h0A, 4); send(8'h0B, 4); send(8'h0C, 4);
    send(8'h0D, 2); send(8'h0E, 2); send(8'h0F, 2); send(8'h0A, 2); send(8'h0B, 2);
    // Foreign byte drops to HUNT, then relock.
    send(8'h55, 1); send(8'h0A, 1); send(8'h0B, 1); send(8'h0C, 1);
    // Resync on FIRST while expecting 0C.
    send(8'h0D, 0); send(8'h0E, 0); send(8'h0F, 0); send(8'h0A, 0); send(8'h0B, 0);
    send(8'h0A, 1); send(8'h0B, 1); send(8'h0C, 1);
    // Silence until timeout.
    repeat (110) drive(1'b0, 1'b0, 8'h00);
    // Relock, then land a byte exactly on the terminal cycle.
    send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 99);
    send(8'h0D, 10);
    // Back-to-back bytes.
    send(8'h0E, 0); send(8'h0F, 0); send(8'h0A, 0); send(8'h0B, 3);
    // Randomized traffic: mostly in-pattern, with random corruptions and long gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) b = m_track ? 8'(pat(m_pos)) : 8'(FIRST);
      else b = 8'($urandom);
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(95, 105) : $urandom_range(0, 5);
      send(b, gap);
    end
    // Alternating mismatches to drive the error count into saturation.
    for (int i = 0; i < 600; i++) send((i % 2 == 0) ? 8'h0A : 8'h0C, 0);
    send(8'h0A, 0);
    // Reset mid-stream with a coincident byte, then resume.
    drive(1'b1, 1'b1, 8'h0C);
    drive(1'b0, 1'b1, 8'h0A);
    send(8'h0B, 0); send(8'h0C, 2);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    @(posedge CLK);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
